// File: rtl/serial_add_seq.sv
// Bit-serial adder: two half adders plus a carry flip-flop iterated LSB-first over WIDTH cycles.
// Define SERIAL_ADD_SUB_EN to add the Sub input (A - B via ~B and a carry-in of 1).
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             Sub,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rs_next;
    logic [WIDTH-1:0] b_load;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic             carry_next;
    logic             ha1_sum;
    logic             ha1_carry;
    logic             ha2_carry;
    logic             sum_bit;
    logic             last_bit;
    logic             load;
    logic             sub_sel;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = Sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    assign b_load   = sub_sel ? ~B : B;
    assign last_bit = (count == CNT_W'(WIDTH - 1));

    always_comb begin
        ha1_sum    = ra[0] ^ rb[0];
        ha1_carry  = ra[0] & rb[0];
        sum_bit    = ha1_sum ^ carry;
        ha2_carry  = ha1_sum & carry;
        carry_next = ha1_carry | ha2_carry;
    end

    // New sum bit enters at the MSB end so the LSB-first stream lands in place after WIDTH shifts.
    assign rs_next = WIDTH'({sum_bit, rs} >> 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // S and Co only update on the final shift, so they hold the previous result while busy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            carry <= 1'b0;
            count <= '0;
            S     <= '0;
            Co    <= 1'b0;
        end else if (load) begin
            ra    <= A;
            rb    <= b_load;
            rs    <= '0;
            carry <= sub_sel;
            count <= '0;
        end else if (state == SHIFT) begin
            ra    <= ra >> 1;
            rb    <= rb >> 1;
            rs    <= rs_next;
            carry <= carry_next;
            count <= count + CNT_W'(1);
            if (last_bit) begin
                S  <= rs_next;
                Co <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized scoreboard bench for serial_add_seq: expectations are queued at launch and
// popped by a monitor on every Done pulse.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef SERIAL_ADD_SUB_EN
    logic         Sub;
`endif
    logic         Busy;
    logic         Done;
    logic [W-1:0] S;
    logic         Co;

    logic [W:0]   exp_q[$];
    int           n_checks;
    int           n_fail;
    int           done_seen;
    int           cycle;

    serial_add_seq #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .A     (A),
        .B     (B),
`ifdef SERIAL_ADD_SUB_EN
        .Sub   (Sub),
`endif
        .Busy  (Busy),
        .Done  (Done),
        .S     (S),
        .Co    (Co)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycle++;

    // Plain arithmetic reference: {carry-out, sum} for add; for subtract Co means A >= B.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
        longint unsigned full;
        logic [W:0] r;
        if (sub) begin
            full = (longint'(a) - longint'(b)) % (longint'(1) << W);
            r    = {(a >= b), W'(full)};
        end else begin
            full = longint'(a) + longint'(b);
            r    = (W+1)'(full);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: no Done within cycle budget", name);
    endtask

    // Launches one operation and checks handshake timing; the monitor checks the result.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        int           cyc;
        int           busy_cnt;
        logic         s_stable;
        logic [W-1:0] s_before;
        @(negedge CLK);
        A     = a;
        B     = b;
`ifdef SERIAL_ADD_SUB_EN
        Sub   = sub;
`endif
        Start = 1'b1;
        exp_q.push_back(model(a, b, sub));
        @(negedge CLK);
        Start    = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        s_before = S;
        s_stable = 1'b1;
        cyc      = 0;
        busy_cnt = 0;
        while (!Done && cyc < 4 * W + 10) begin
            if (Busy) busy_cnt++;
            if (S !== s_before) s_stable = 1'b0;
            @(negedge CLK);
            cyc++;
        end
        checkOutput("done_latency", 64'(cyc), 64'(W));
        checkOutput("busy_cycles", 64'(busy_cnt), 64'(W));
        checkOutput("s_held_while_busy", 64'(s_stable), 64'd1);
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        logic [W:0] e;
        if (!RST && Done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_done: got Done, expected none");
            end else begin
                e = exp_q.pop_front();
                checkOutput("sum", 64'(S), 64'(e[W-1:0]));
                checkOutput("carry", 64'(Co), 64'(e[W]));
                checkOutput("busy_in_done", 64'(Busy), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int done_before;
        int prev;
        int wait_cnt;
        logic sub_r;

        n_checks  = 0;
        n_fail    = 0;
        done_seen = 0;
        cycle     = 0;
        RST       = 1'b1;
        Start     = 1'b0;
        A         = '0;
        B         = '0;
`ifdef SERIAL_ADD_SUB_EN
        Sub       = 1'b0;
`endif
        repeat (3) @(negedge CLK);
        checkOutput("reset_busy", 64'(Busy), 64'd0);
        checkOutput("reset_done", 64'(Done), 64'd0);
        checkOutput("reset_s", 64'(S), 64'd0);
        checkOutput("reset_co", 64'(Co), 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        applyStimulus(8'h03, 8'h05, 1'b0);
        checkOutput("s_03_05", 64'(S), 64'h08);
        checkOutput("co_03_05", 64'(Co), 64'd0);
        applyStimulus(8'hFF, 8'h01, 1'b0);
        checkOutput("s_ff_01", 64'(S), 64'h00);
        checkOutput("co_ff_01", 64'(Co), 64'd1);
        applyStimulus(8'hAA, 8'h55, 1'b0);
        checkOutput("s_aa_55", 64'(S), 64'hFF);
        checkOutput("co_aa_55", 64'(Co), 64'd0);

        // Start re-asserted with new operands while busy must be ignored.
        done_before = done_seen;
        @(negedge CLK);
        A     = 8'h03;
        B     = 8'h05;
        Start = 1'b1;
        exp_q.push_back(model(8'h03, 8'h05, 1'b0));
        @(negedge CLK);
        A = 8'h11;
        repeat (3) @(negedge CLK);
        Start = 1'b0;
        repeat (3 * W) @(negedge CLK);
        checkOutput("ignored_start_done_count", 64'(done_seen - done_before), 64'd1);
        checkOutput("ignored_start_s", 64'(S), 64'h08);

        // Leave a result with S != 0 and Co = 1, then reset mid-operation.
        applyStimulus(8'hF0, 8'h20, 1'b0);
        @(negedge CLK);
        A     = 8'h12;
        B     = 8'h34;
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("async_reset_busy", 64'(Busy), 64'd0);
        checkOutput("async_reset_done", 64'(Done), 64'd0);
        checkOutput("async_reset_s", 64'(S), 64'd0);
        checkOutput("async_reset_co", 64'(Co), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        done_before = done_seen;
        repeat (2 * W) @(negedge CLK);
        checkOutput("no_done_after_reset", 64'(done_seen - done_before), 64'd0);
        applyStimulus(8'h12, 8'h34, 1'b0);
        checkOutput("s_after_reset", 64'(S), 64'h46);

        // Start held high: back-to-back operations every W+2 cycles.
        for (int n = 0; n < 4; n++) exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(negedge CLK);
        A     = 8'h10;
        B     = 8'h20;
        Start = 1'b1;
        prev  = -1;
        for (int n = 0; n < 4; n++) begin
            wait_cnt = 0;
            while (!Done && wait_cnt < 40) begin
                @(negedge CLK);
                wait_cnt++;
            end
            if (!Done) begin
                reportFail("b2b_wait");
            end else begin
                if (prev >= 0) checkOutput("b2b_period", 64'(cycle - prev), 64'(W + 2));
                prev = cycle;
            end
            if (n == 3) Start = 1'b0;
            @(negedge CLK);
        end
        repeat (2 * W) @(negedge CLK);

        for (int i = 0; i < 20; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            sub_r = 1'($urandom_range(0, 1));
`else
            sub_r = 1'b0;
`endif
            applyStimulus(W'($urandom), W'($urandom), sub_r);
        end

`ifdef SERIAL_ADD_SUB_EN
        applyStimulus(8'h05, 8'h03, 1'b1);
        checkOutput("sub_s_05_03", 64'(S), 64'h02);
        checkOutput("sub_co_05_03", 64'(Co), 64'd1);
        applyStimulus(8'h03, 8'h05, 1'b1);
        checkOutput("sub_s_03_05", 64'(S), 64'hFE);
        checkOutput("sub_co_03_05", 64'(Co), 64'd0);
`endif

        repeat (4) @(negedge CLK);
        checkOutput("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
